// File: rtl/simon_serial_pkg.sv
// Shared definitions for the digit-serial SIMON datapath: control states,
// standard round counts, parameter legality and modular index helper.
package simon_serial_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    RUN    = 2'd2,
    UNLOAD = 2'd3
  } state_e;

  // Standard SIMON round count for word size n and key words m (0 if unknown).
  function automatic int unsigned rounds_for(input int unsigned n, input int unsigned m);
    int unsigned r;
    r = 0;
    case (n)
      16: if (m == 4) r = 32;
      24: if (m == 3 || m == 4) r = 36;
      32: r = (m == 3) ? 42 : ((m == 4) ? 44 : 0);
      48: r = (m == 2) ? 52 : ((m == 3) ? 54 : 0);
      64: r = (m == 2) ? 68 : ((m == 3) ? 69 : ((m == 4) ? 72 : 0));
      default: r = 0;
    endcase
    return r;
  endfunction

  // True when the word size, digit width and round count form a usable datapath.
  function automatic bit params_legal(input int unsigned n, input int unsigned d,
                                      input int unsigned rounds);
    bit n_ok;
    n_ok = (n == 16) || (n == 24) || (n == 32) || (n == 48) || (n == 64);
    return n_ok && (d >= 1) && (d <= 8) && ((n % d) == 0) && (rounds >= 2);
  endfunction

  // (j - off) mod n for 0 <= j < n and off <= n, without a divider.
  function automatic int unsigned wrap_back(input int unsigned j, input int unsigned off,
                                            input int unsigned n);
    return (j >= off) ? (j - off) : (j + n - off);
  endfunction

endpackage

// File: rtl/simon_f_digit.sv
// Combinational SIMON round function for one D-bit digit.
//   x_i      : full x word (held static across a round)
//   y_i      : current y digit (bits c*D .. c*D+D-1 of y)
//   k_i      : current round-key digit
//   idx_i    : digit index c within the word
//   xnew_c_o : new x bits c*D .. c*D+D-1
module simon_f_digit
  import simon_serial_pkg::*;
#(
  parameter int unsigned N = 64,
  parameter int unsigned D = 1,
  localparam int unsigned CW = $clog2(N / D),
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  x_i,
  input  logic [D-1:0]  y_i,
  input  logic [D-1:0]  k_i,
  input  logic [CW-1:0] idx_i,
  output logic [D-1:0]  xnew_c_o
);

  // Left rotations by 1, 2 and 8 become reads of x at j-1, j-2, j-8 mod N.
  for (genvar t = 0; t < D; t++) begin : g_bit
    logic [IW-1:0] s1;
    logic [IW-1:0] s2;
    logic [IW-1:0] s8;

    always_comb begin
      s1 = IW'(wrap_back(32'(idx_i) * D + 32'(t), 1, N));
      s2 = IW'(wrap_back(32'(idx_i) * D + 32'(t), 2, N));
      s8 = IW'(wrap_back(32'(idx_i) * D + 32'(t), 8, N));
    end

    assign xnew_c_o[t] = y_i[t] ^ (x_i[s1] & x_i[s8]) ^ x_i[s2] ^ k_i[t];
  end

endmodule

// File: rtl/simon_datapath_digit_serial.sv
// Digit-serial SIMON 2N/mN encryption datapath, D bits per clock.
//   clk, reset     : clock, synchronous active-low reset
//   start          : begin a block (IDLE only)
//   pt_digit/valid : plaintext digits, y LSB digit first then x (LOAD only)
//   key_digit      : round-key digit for (round_cnt, digit_cnt), sampled while key_req
//   key_req        : high in RUN
//   round_cnt      : current round
//   digit_cnt      : digit index within the current phase
//   ct_digit/valid : ciphertext digits in load order, with ct_ready handshake
//   busy           : block in progress
//   done           : one-cycle pulse after the last ciphertext handshake
module simon_datapath_digit_serial
  import simon_serial_pkg::*;
#(
  parameter int unsigned N      = 64,
  parameter int unsigned D      = 1,
  parameter int unsigned ROUNDS = rounds_for(64, 2),
  localparam int unsigned RW    = $clog2(ROUNDS),
  localparam int unsigned DCW   = $clog2(2 * N / D)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [D-1:0]   pt_digit,
  input  logic           pt_valid,
  input  logic [D-1:0]   key_digit,
  output logic           key_req,
  output logic [RW-1:0]  round_cnt,
  output logic [DCW-1:0] digit_cnt,
  output logic [D-1:0]   ct_digit,
  output logic           ct_valid,
  input  logic           ct_ready,
  output logic           busy,
  output logic           done
);

  localparam int unsigned CW      = $clog2(N / D);
  localparam int unsigned RUN_LAST = N / D - 1;
  localparam int unsigned IO_LAST  = 2 * N / D - 1;

  if (!params_legal(N, D, ROUNDS)) begin : g_param_check
    $error("simon_datapath_digit_serial: illegal N/D/ROUNDS combination");
  end

  state_e         state_q;
  logic [N-1:0]   x_q;
  logic [N-1:0]   y_q;
  // Lowest digit of the new-x accumulator is never read back before commit,
  // so only the upper N-D bits are stored.
  logic [N-D-1:0] xn_q;
  logic [RW-1:0]  round_cnt_q;
  logic [DCW-1:0] digit_cnt_q;
  logic           busy_q;
  logic           done_q;

  logic [D-1:0]   xnew_c;
  logic [N-1:0]   xn_full_d;

  simon_f_digit #(.N(N), .D(D)) u_f_digit (
    .x_i      (x_q),
    .y_i      (y_q[D-1:0]),
    .k_i      (key_digit),
    .idx_i    (digit_cnt_q[CW-1:0]),
    .xnew_c_o (xnew_c)
  );

  // Accumulator with this cycle's digit shifted in at the top.
  assign xn_full_d = {xnew_c, xn_q};

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      xn_q        <= '0;
      round_cnt_q <= '0;
      digit_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= LOAD;
            digit_cnt_q <= '0;
            busy_q      <= 1'b1;
          end
        end

        LOAD: begin
          if (pt_valid) begin
            {x_q, y_q} <= {pt_digit, x_q, y_q[N-1:D]};
            if (digit_cnt_q == DCW'(IO_LAST)) begin
              state_q     <= RUN;
              digit_cnt_q <= '0;
              round_cnt_q <= '0;
            end else begin
              digit_cnt_q <= digit_cnt_q + DCW'(1);
            end
          end
        end

        RUN: begin
          xn_q <= xn_full_d[N-1:D];
          if (digit_cnt_q == DCW'(RUN_LAST)) begin
            // Round commit: Feistel swap with the completed new x.
            y_q         <= x_q;
            x_q         <= xn_full_d;
            digit_cnt_q <= '0;
            if (round_cnt_q == RW'(ROUNDS - 1)) begin
              state_q     <= UNLOAD;
              round_cnt_q <= '0;
            end else begin
              round_cnt_q <= round_cnt_q + RW'(1);
            end
          end else begin
            y_q         <= y_q >> D;
            digit_cnt_q <= digit_cnt_q + DCW'(1);
          end
        end

        UNLOAD: begin
          if (ct_ready) begin
            {x_q, y_q} <= {{D{1'b0}}, x_q, y_q[N-1:D]};
            if (digit_cnt_q == DCW'(IO_LAST)) begin
              state_q     <= IDLE;
              digit_cnt_q <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              digit_cnt_q <= digit_cnt_q + DCW'(1);
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign key_req   = (state_q == RUN);
  assign ct_valid  = (state_q == UNLOAD);
  assign ct_digit  = y_q[D-1:0];
  assign round_cnt = round_cnt_q;
  assign digit_cnt = digit_cnt_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
